// File: rtl/calc_pkg.sv
// Shared calculator definitions: multiplier width, FSM state encoding and
// the iteration counter width used by seq_shift_add_mul.
package calc_pkg;

  localparam int unsigned MUL_WIDTH = 16;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH + 1);

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MUL_IDLE,
    ST_RUN  = MUL_RUN,
    ST_DONE = MUL_DONE
  } mul_state_e;

endpackage

// File: rtl/shift_add_step.sv
// One combinational shift-add iteration: conditionally add the multiplicand
// into the partial product, then shift multiplicand left and multiplier right.
// Ports:
//   prod_i / mcand_i   : current partial product and multiplicand (2*WIDTH)
//   mplier_i           : current multiplier (WIDTH)
//   prod_c_o / mcand_c_o / mplier_c_o : next-iteration values (combinational)
module shift_add_step
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] prod_c_o,
  output logic [2*WIDTH-1:0] mcand_c_o,
  output logic [WIDTH-1:0]   mplier_c_o
);

  // Product cannot overflow: mcand only carries the original WIDTH-bit operand
  // shifted by at most WIDTH-1, so the sum stays below (2^W-1)^2 + 1.
  assign prod_c_o   = mplier_i[0] ? (prod_i + mcand_i) : prod_i;
  assign mcand_c_o  = mcand_i << 1;
  assign mplier_c_o = mplier_i >> 1;

endmodule

// File: rtl/seq_shift_add_mul.sv
// Multi-cycle unsigned shift-add multiplier with start/done handshake.
// The product is held in res between operations so the downstream mux can
// sample it at any time after done.
// Build option: define MUL_EARLY_TERM_EN to leave RUN as soon as the shifted
// multiplier becomes zero (same result, shorter busy); otherwise the
// operation always takes WIDTH iterations.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : request a multiply (accepted in IDLE or DONE only)
//   A, B  : multiplicand / multiplier, captured on the accepted-start edge
//   res   : 2*WIDTH-bit product, updated only on the completing edge
//   done  : high while res holds the result of the last accepted operation
//   busy  : high while iterating
module seq_shift_add_mul
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] res,
  output logic               done,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  mul_state_e        state_q, state_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     res_q, res_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [PW-1:0]     prod_nxt_c;
  logic [PW-1:0]     mcand_nxt_c;
  logic [WIDTH-1:0]  mplier_nxt_c;
  logic [CW-1:0]     count_inc_c;
  logic              last_iter_c;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .prod_i     (prod_q),
    .mcand_i    (mcand_q),
    .mplier_i   (mplier_q),
    .prod_c_o   (prod_nxt_c),
    .mcand_c_o  (mcand_nxt_c),
    .mplier_c_o (mplier_nxt_c)
  );

  assign count_inc_c = count_q + CW'(1);

  // Termination condition for the current RUN iteration.
`ifdef MUL_EARLY_TERM_EN
  assign last_iter_c = (mplier_nxt_c == '0) || (count_inc_c == CW'(WIDTH));
`else
  assign last_iter_c = (count_inc_c == CW'(WIDTH));
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      res_q    <= res_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    res_d    = res_q;
    done_d   = done_q;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new start drops done on the same edge it captures the operands.
        if (start) begin
          mcand_d  = PW'(A);
          mplier_d = B;
          prod_d   = '0;
          count_d  = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        prod_d   = prod_nxt_c;
        mcand_d  = mcand_nxt_c;
        mplier_d = mplier_nxt_c;
        count_d  = count_inc_c;
        if (last_iter_c) begin
          res_d   = prod_nxt_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign res  = res_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
